i2s_dac_tx: RTL

Serial audio transmitter for the codec DAC path: the outbound counterpart of the ADC capture path in the `audio` block. It accepts signed left/right sample pairs over a valid/ready handshake and serialises them onto `dacdat` in I2S format. It generates `bclk` and `daclrck` itself from `clkin`, so the codec runs as a slave. It sits between any sample source (tone generator, inverse transform, loopback of captured samples) and the codec pins.

---
 rtl/i2s_dac_tx.sv | 98 +++++++++
 1 files changed

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: generates bclk/daclrck from clkin (codec as slave) and
// serialises buffered left/right sample pairs MSB-first with a one-bit delay.
module i2s_dac_tx #(
  parameter int width     = 16,
  parameter int slot_bits = 32,
  parameter int bclk_div  = 8
) (
  input  logic             clkin,
  input  logic             swt,
  input  logic [width-1:0] sample_l,
  input  logic [width-1:0] sample_r,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             bclk,
  output logic             daclrck,
  output logic             dacdat,
  output logic             underrun
);

  localparam int frame_bits = 2 * slot_bits;
  localparam int div_w      = (bclk_div > 1) ? $clog2(bclk_div) : 1;
  localparam int cnt_w      = $clog2(frame_bits);
  localparam int idx_w      = (width > 1) ? $clog2(width) : 1;

  logic [div_w-1:0] div_cnt;
  logic [cnt_w-1:0] b;
  logic [width-1:0] hold_l, hold_r;
  logic [width-1:0] shift_l, shift_r;
  logic             full;

  logic             div_tc, fall, frame_start, accept, full_next;
  logic             lrck_next, dat_next;
  logic [cnt_w-1:0] b_next, p_next;
  logic [idx_w-1:0] idx;
  logic [width-1:0] chan;
  int unsigned      pos;

  always_comb begin
    div_tc      = (div_cnt == div_w'(bclk_div - 1));
    fall        = div_tc & bclk;
    b_next      = (b == cnt_w'(frame_bits - 1)) ? '0 : b + 1'b1;
    frame_start = fall & (b_next == '0);
    accept      = sample_valid & ~full;
    // A pair can only be accepted while empty, so set and clear never collide.
    full_next   = accept | (full & ~frame_start);
    lrck_next   = (b_next >= cnt_w'(slot_bits));
    p_next      = lrck_next ? b_next - cnt_w'(slot_bits) : b_next;
    chan        = lrck_next ? shift_r : shift_l;
    pos         = 32'(p_next);
    idx         = '0;
    dat_next    = 1'b0;
    if (pos >= 1 && pos <= width) begin
      idx      = idx_w'(width - pos);
      dat_next = chan[idx];
    end
  end

  always_ff @(posedge clkin or negedge swt) begin
    if (!swt) begin
      div_cnt      <= '0;
      b            <= cnt_w'(frame_bits - 1);
      bclk         <= 1'b0;
      daclrck      <= 1'b1;
      dacdat       <= 1'b0;
      sample_ready <= 1'b1;
      underrun     <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      shift_l      <= '0;
      shift_r      <= '0;
      full         <= 1'b0;
    end else begin
      div_cnt  <= div_tc ? '0 : div_cnt + 1'b1;
      underrun <= 1'b0;
      if (div_tc) bclk <= ~bclk;
      if (fall) begin
        b       <= b_next;
        daclrck <= lrck_next;
        dacdat  <= dat_next;
        if (frame_start) begin
          if (full) begin
            shift_l <= hold_l;
            shift_r <= hold_r;
          end else begin
            underrun <= 1'b1;
          end
        end
      end
      if (accept) begin
        hold_l <= sample_l;
        hold_r <= sample_r;
      end
      full         <= full_next;
      sample_ready <= ~full_next;
    end
  end

endmodule
